// File: rtl/input_buffer_loader_if.sv
// Operand stream, input-buffer shift port and tile handshake between fetch, loader and compute core.
interface input_buffer_loader_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 6
);
    logic                  start;
    logic                  clear;
    logic                  abort;
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  buf_enable;
    logic [DATA_WIDTH-1:0] buf_data;
    logic                  tile_valid;
    logic                  tile_ack;
    logic                  busy;
    logic [CNT_W-1:0]      load_count;
    logic [15:0]           tile_count;

    modport master (
        output start, clear, abort, s_valid, s_data, tile_ack,
        input  s_ready, buf_enable, buf_data, tile_valid, busy, load_count, tile_count
    );

    modport slave (
        input  start, clear, abort, s_valid, s_data, tile_ack,
        output s_ready, buf_enable, buf_data, tile_valid, busy, load_count, tile_count
    );
endinterface

// File: rtl/input_buffer_loader.sv
// Fills the TCU input shift buffer with one DEPTH-word tile from a valid/ready stream,
// hands the tile to the compute core and can flush the buffer to zero.
module input_buffer_loader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 48,
    parameter int unsigned CNT_W      = 6
) (
    input logic                 clk,
    input logic                 rst,
    input_buffer_loader_if.slave bus
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE, FLUSH} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [15:0]      tile_cnt_q, tile_cnt_d;

    // State, word counter and completed-tile counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tile_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tile_cnt_q <= tile_cnt_d;
        end
    end

    // Next state and state-decoded buffer/stream controls
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        tile_cnt_d      = tile_cnt_q;
        bus.s_ready     = 1'b0;
        bus.buf_enable  = 1'b0;
        bus.buf_data    = '0;
        bus.tile_valid  = 1'b0;
        bus.busy        = (state_q != IDLE);
        bus.load_count  = '0;

        unique case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (bus.start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                bus.load_count = cnt_q;
                if (bus.abort) begin
                    // abort wins over a same-cycle word: it is never shifted in
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else begin
                    bus.s_ready = 1'b1;
                    if (bus.s_valid) begin
                        bus.buf_enable = 1'b1;
                        bus.buf_data   = DATA_WIDTH'(bus.s_data);
                        if (cnt_q == LAST) begin
                            state_d = DONE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            DONE: begin
                bus.tile_valid = 1'b1;
                if (bus.abort) begin
                    state_d = FLUSH;
                    cnt_d   = '0;
                end else if (bus.tile_ack) begin
                    state_d    = IDLE;
                    tile_cnt_d = tile_cnt_q + 16'd1;
                end
            end
            FLUSH: begin
                bus.buf_enable = 1'b1;
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign bus.tile_count = tile_cnt_q;
endmodule

// File: tb/tb_input_buffer_loader.sv
// Randomized and directed checks of input_buffer_loader against a tile-level reference model.
module tb_input_buffer_loader;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 48;
    localparam int unsigned CW    = 6;

    logic clk = 1'b0;
    logic rst = 1'b0;

    input_buffer_loader_if #(.DATA_WIDTH(DW), .CNT_W(CW)) bus ();

    input_buffer_loader #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 loading, 2 tile ready, 3 flushing
    int            m_mode       = 0;
    logic [DW-1:0] m_tile[$];
    int            m_flush_left = 0;
    logic [15:0]   m_tiles      = '0;

    // Bench view of the physical buffer, built from the DUT's shift port
    logic [DW-1:0] shadow[DEPTH];
    int            en_pulses = 0;
    bit            tv_seen   = 1'b0;

    task automatic model_reset();
        m_mode = 0;
        m_tile.delete();
        m_flush_left = 0;
        m_tiles = '0;
    endtask

    always @(negedge rst) model_reset();

    always @(negedge clk) begin
        logic          e_ready, e_en, e_tv, e_busy;
        logic [DW-1:0] e_data;
        logic [CW-1:0] e_lc;
        if (!rst) begin
            model_reset();
            chk("rst_s_ready", 64'(bus.s_ready), 64'd0);
            chk("rst_buf_enable", 64'(bus.buf_enable), 64'd0);
            chk("rst_buf_data", 64'(bus.buf_data), 64'd0);
            chk("rst_tile_valid", 64'(bus.tile_valid), 64'd0);
            chk("rst_busy", 64'(bus.busy), 64'd0);
            chk("rst_load_count", 64'(bus.load_count), 64'd0);
            chk("rst_tile_count", 64'(bus.tile_count), 64'd0);
        end else begin
            e_ready = (m_mode == 1) && !bus.abort;
            e_en    = (e_ready && bus.s_valid) || (m_mode == 3);
            e_data  = (e_ready && bus.s_valid) ? bus.s_data : '0;
            e_tv    = (m_mode == 2);
            e_busy  = (m_mode != 0);
            e_lc    = (m_mode == 1) ? CW'(m_tile.size()) : '0;
            chk("s_ready", 64'(bus.s_ready), 64'(e_ready));
            chk("buf_enable", 64'(bus.buf_enable), 64'(e_en));
            chk("buf_data", 64'(bus.buf_data), 64'(e_data));
            chk("tile_valid", 64'(bus.tile_valid), 64'(e_tv));
            chk("busy", 64'(bus.busy), 64'(e_busy));
            chk("load_count", 64'(bus.load_count), 64'(e_lc));
            chk("tile_count", 64'(bus.tile_count), 64'(m_tiles));

            if (bus.buf_enable) begin
                en_pulses++;
                for (int i = 0; i < DEPTH - 1; i++) shadow[i] = shadow[i+1];
                shadow[DEPTH-1] = bus.buf_data;
            end
            if (bus.tile_valid) tv_seen = 1'b1;

            // Advance the model with the inputs the next rising edge will see
            case (m_mode)
                0: begin
                    if (bus.clear) begin
                        m_mode = 3;
                        m_flush_left = DEPTH;
                    end else if (bus.start) begin
                        m_mode = 1;
                        m_tile.delete();
                    end
                end
                1: begin
                    if (bus.abort) begin
                        m_mode = 3;
                        m_flush_left = DEPTH;
                    end else if (bus.s_valid) begin
                        m_tile.push_back(bus.s_data);
                        if (m_tile.size() == DEPTH) m_mode = 2;
                    end
                end
                2: begin
                    if (bus.abort) begin
                        m_mode = 3;
                        m_flush_left = DEPTH;
                    end else if (bus.tile_ack) begin
                        m_mode = 0;
                        m_tiles = m_tiles + 16'd1;
                    end
                end
                default: begin
                    m_flush_left--;
                    if (m_flush_left == 0) m_mode = 0;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.start = 1'b0; bus.clear = 1'b0; bus.abort = 1'b0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.tile_ack = 1'b0;
    endtask

    task automatic wait_tile(input string name, input int budget);
        int n = 0;
        while (!bus.tile_valid && n < budget) begin
            bus.s_valid = 1'($urandom_range(0, 1));
            bus.s_data  = $urandom;
            tick();
            n++;
        end
        bus.s_valid = 1'b0;
        chk(name, 64'(bus.tile_valid), 64'd1);
    endtask

    task automatic ack_tile();
        bus.tile_ack = 1'b1;
        tick();
        bus.tile_ack = 1'b0;
    endtask

    initial begin
        logic [15:0] tc_before;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) shadow[i] = '0;

        // Reset held with inputs toggling
        for (int i = 0; i < 6; i++) begin
            bus.start = 1'($urandom); bus.clear = 1'($urandom); bus.abort = 1'($urandom);
            bus.s_valid = 1'($urandom); bus.s_data = $urandom; bus.tile_ack = 1'($urandom);
            tick();
        end
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();

        // Full back-to-back tile of words 1..48
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        en_pulses = 0;
        for (int i = 1; i <= DEPTH; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = DW'(i);
            tick();
        end
        idle_inputs();
        chk("t2_tile_valid_next_cycle", 64'(bus.tile_valid), 64'd1);
        chk("t2_enables", 64'(en_pulses), 64'd48);
        chk("t2_buffer0", 64'(shadow[0]), 64'd1);
        chk("t2_buffer23", 64'(shadow[23]), 64'd24);
        chk("t2_buffer47", 64'(shadow[DEPTH-1]), 64'd48);
        ack_tile();
        chk("t2_tile_count", 64'(bus.tile_count), 64'd1);
        chk("t2_idle", 64'(bus.busy), 64'd0);

        // Alternating-valid stream: 48 accepts over 96 cycles
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        en_pulses = 0;
        for (int i = 0; i < 2 * DEPTH; i++) begin
            bus.s_valid = ((i % 2) == 0);
            bus.s_data  = $urandom;
            tick();
        end
        bus.s_valid = 1'b0;
        chk("t3_enables", 64'(en_pulses), 64'd48);
        chk("t3_tile_valid", 64'(bus.tile_valid), 64'd1);

        // DONE ignores stream and start while unacknowledged
        en_pulses = 0;
        bus.s_valid = 1'b1; bus.start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus.s_data = $urandom;
            tick();
        end
        chk("t4_enables", 64'(en_pulses), 64'd0);
        chk("t4_tile_valid_held", 64'(bus.tile_valid), 64'd1);
        chk("t4_s_ready", 64'(bus.s_ready), 64'd0);
        idle_inputs();
        ack_tile();
        chk("t4_tile_count", 64'(bus.tile_count), 64'd2);
        chk("t4_idle", 64'(bus.busy), 64'd0);

        // Abort mid-load flushes DEPTH zero words
        tc_before = bus.tile_count;
        tv_seen = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom | 32'h1;
            tick();
        end
        chk("t5_load_count_20", 64'(bus.load_count), 64'd20);
        en_pulses = 0;
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        for (int i = 0; i < DEPTH; i++) tick();
        bus.s_valid = 1'b0;
        chk("t5_flush_enables", 64'(en_pulses), 64'd48);
        chk("t5_flushed_buffer", 64'(shadow[5] | shadow[DEPTH-1]), 64'd0);
        chk("t5_idle", 64'(bus.busy), 64'd0);
        chk("t5_no_tile", 64'(tv_seen), 64'd0);
        chk("t5_tile_count", 64'(bus.tile_count), 64'(tc_before));

        // Asynchronous reset mid-load
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = $urandom;
            tick();
        end
        chk("t6_load_count_30", 64'(bus.load_count), 64'd30);
        #1 rst = 1'b0;
        #1;
        chk("t6_async_busy", 64'(bus.busy), 64'd0);
        chk("t6_async_load_count", 64'(bus.load_count), 64'd0);
        chk("t6_async_enable", 64'(bus.buf_enable), 64'd0);
        chk("t6_async_tile_count", 64'(bus.tile_count), 64'd0);
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        chk("t6_after_busy", 64'(bus.busy), 64'd0);
        en_pulses = 0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_tile("t6_new_tile", 500);
        chk("t6_full_tile_enables", 64'(en_pulses), 64'd48);
        ack_tile();

        // Random traffic including clear, abort and ack
        for (int i = 0; i < 2500; i++) begin
            bus.start    = ($urandom_range(0, 7) == 0);
            bus.clear    = ($urandom_range(0, 39) == 0);
            bus.abort    = ($urandom_range(0, 59) == 0);
            bus.s_valid  = ($urandom_range(0, 2) != 0);
            bus.s_data   = $urandom;
            bus.tile_ack = ($urandom_range(0, 3) == 0);
            tick();
        end
        idle_inputs();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
